instruction_loader: RTL and testbench
=====================================

// Module: instruction_loader
// PURPOSE
//  Write-side initiator for the instruction memory: takes a byte stream (valid/ready, e.g. from a UART receiver)
//  carrying a program image and writes it sequentially into instruction memory via its Address/Data_in/WE port.
//  While loading it asserts Cpu_hold; the top level uses this to freeze the CPU and steer the memory address mux
//  to Mem_address instead of the PC. Stream frame: LEN byte, LEN data bytes, [checksum byte].
// PARAMETERS
//  ADDR_WIDTH  8   width of Mem_address
//  DEPTH       64  instruction memory words; max accepted LEN
//  DATA_WIDTH  8   instruction/byte width
// PORTS
//  Clock        in   1           single clock, all state on rising edge
//  Reset        in   1           asynchronous, active-high; clears all state immediately
//  Start        in   1           pulse: begin a load (sampled only in IDLE, DONE, ERROR)
//  Rx_valid     in   1           stream byte valid
//  Rx_data      in   DATA_WIDTH  stream byte
//  Rx_ready     out  1           loader accepts byte; transfer = Rx_valid & Rx_ready on a rising edge
//  Mem_address  out  ADDR_WIDTH  memory write address
//  Mem_data     out  DATA_WIDTH  memory write data
//  Mem_we       out  1           memory write enable, one-cycle pulse per word
//  Cpu_hold     out  1           loader owns memory; CPU frozen
//  Done         out  1           last load completed OK
//  Error        out  1           last load aborted (bad LEN or checksum)
// BEHAVIOUR
//  Reset: state IDLE; Rx_ready=0, Mem_address=0, Mem_data=0, Mem_we=0, Cpu_hold=0, Done=0, Error=0, count=0, sum=0.
//  States: IDLE, LEN, DATA, WRITE, CHECK (only with macro), DONE, ERROR. All outputs registered.
//  IDLE/DONE/ERROR --Start--> LEN; Done, Error cleared, Mem_address=0, sum=0. Start ignored in other states.
//  LEN: Rx_ready=1. On transfer: LEN==0 or LEN>DEPTH -> ERROR; else count=LEN -> DATA.
//  DATA: Rx_ready=1. On transfer: Mem_data<=Rx_data, sum<=sum+Rx_data (mod 2^DATA_WIDTH) -> WRITE.
//  WRITE: Rx_ready=0, Mem_we=1 exactly one cycle; next cycle Mem_address+1, count-1;
//   count reaches 0 -> CHECK (macro) or DONE; else -> DATA. Max throughput one word per 2 cycles.
//  Mem_address/Mem_data stable throughout the cycle Mem_we=1; never exceeds DEPTH-1 (LEN bound guarantees).
//  DONE: Done=1, Cpu_hold=0, held until Start or Reset. ERROR: Error=1, Cpu_hold=1 (CPU stays frozen on a
//   partial image) until Start or Reset.
//  Cpu_hold=1 in LEN, DATA, WRITE, CHECK, ERROR; 0 in IDLE, DONE. Done and Error never both 1.
//  Rx_valid without Rx_ready: no transfer; source holds byte. Rx_valid in IDLE/DONE/ERROR: ignored (Rx_ready=0).
//  Reset mid-load: outputs to reset values asynchronously; words already written stay in memory.
//  Start and transfer cannot coincide (disjoint states); Reset dominates everything.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after last data word enter CHECK, Rx_ready=1; on transfer Rx_data==sum -> DONE,
//   else ERROR. Frame is LEN+2 bytes.
//  Undefined: no CHECK state, no sum register; WRITE of last word -> DONE. Frame is LEN+1 bytes.
// STRUCTURE
//  Shared package nrisc_loader_pkg: state enum/localparams (IDLE..ERROR), DEPTH default 64, byte width 8.
//  Single flat module; no sub-module (FSM + counter + adder is small). Address mux vs PC lives at top level.
// TESTING
//  1 Reset, Start, stream 03,A1,B2,C3 (no macro) -> Mem_we pulses at addr 0,1,2 with A1,B2,C3; Done=1, Cpu_hold=0.
//  2 Macro on, stream 02,10,20,30 -> 2 writes, Done=1; stream 02,10,20,31 -> Error=1, Done=0, Cpu_hold=1.
//  3 LEN=00 and LEN=41 (65) -> ERROR immediately, no Mem_we pulse; Start then valid frame recovers to Done.
//  4 LEN=40 (64) full image -> last write at Mem_address=3F, no wrap, Done=1.
//  5 Rx_valid toggled randomly / held high during WRITE -> no byte lost or duplicated; Rx_ready=0 in WRITE.
//  6 Reset asserted after 2nd data byte (async, mid-cycle) -> all outputs 0 at once, IDLE; Start re-loads cleanly.

Source files
------------

// File: rtl/nrisc_loader_pkg.sv
// Shared loader definitions: FSM states and default geometry.
// ST_CHECK exists only when LOADER_CHECKSUM_EN is defined.
package nrisc_loader_pkg;

  localparam int DEPTH_DEFAULT = 64;
  localparam int BYTE_WIDTH    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
`ifdef LOADER_CHECKSUM_EN
    , ST_CHECK = 3'd6
`endif
  } loader_state_t;

endpackage

// File: rtl/instruction_loader.sv
// Streams a LEN-prefixed image into instruction memory, one word per 2 cycles; Rx_ready drops while writing.
// Optional LOADER_CHECKSUM_EN adds a trailing checksum byte verified against the mod-2^N byte sum.
module instruction_loader
  import nrisc_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int DATA_WIDTH = BYTE_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Rx_valid,
  input  logic [DATA_WIDTH-1:0] Rx_data,
  output logic                  Rx_ready,
  output logic [ADDR_WIDTH-1:0] Mem_address,
  output logic [DATA_WIDTH-1:0] Mem_data,
  output logic                  Mem_we,
  output logic                  Cpu_hold,
  output logic                  Done,
  output logic                  Error
);

  localparam int CW = $clog2(DEPTH + 1);

  loader_state_t         state, state_nxt;
  logic [CW-1:0]         count, count_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  xfer;
  logic                  len_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum, sum_nxt;
`endif

  assign xfer    = Rx_valid & Rx_ready;
  assign len_bad = (Rx_data == '0) || (int'(Rx_data) > DEPTH);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    addr_nxt  = Mem_address;
    data_nxt  = Mem_data;
`ifdef LOADER_CHECKSUM_EN
    sum_nxt   = sum;
`endif
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          state_nxt = ST_LEN;
          addr_nxt  = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_nxt   = '0;
`endif
        end
      end
      ST_LEN: begin
        if (xfer) begin
          if (len_bad) begin
            state_nxt = ST_ERROR;
          end else begin
            count_nxt = CW'(Rx_data);
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          data_nxt  = Rx_data;
`ifdef LOADER_CHECKSUM_EN
          sum_nxt   = sum + Rx_data;
`endif
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        count_nxt = count - CW'(1);
        // Address is not advanced past the last word so it never leaves 0..DEPTH-1.
        if (count == CW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          addr_nxt  = Mem_address + ADDR_WIDTH'(1);
          state_nxt = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) state_nxt = (Rx_data == sum) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      Mem_address <= '0;
      Mem_data    <= '0;
      Rx_ready    <= 1'b0;
      Mem_we      <= 1'b0;
      Cpu_hold    <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      Mem_address <= addr_nxt;
      Mem_data    <= data_nxt;
`ifdef LOADER_CHECKSUM_EN
      Rx_ready    <= (state_nxt == ST_LEN) || (state_nxt == ST_DATA) || (state_nxt == ST_CHECK);
      sum         <= sum_nxt;
`else
      Rx_ready    <= (state_nxt == ST_LEN) || (state_nxt == ST_DATA);
`endif
      Mem_we      <= (state_nxt == ST_WRITE);
      Cpu_hold    <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      Done        <= (state_nxt == ST_DONE);
      Error       <= (state_nxt == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized frame bench for instruction_loader; builds the expected memory writes per frame.
// Honors LOADER_CHECKSUM_EN by appending a checksum byte to each frame.
module tb_instruction_loader;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       cpu_hold;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  instruction_loader #(.ADDR_WIDTH(8), .DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Start      (start),
    .Rx_valid   (rx_valid),
    .Rx_data    (rx_data),
    .Rx_ready   (rx_ready),
    .Mem_address(mem_address),
    .Mem_data   (mem_data),
    .Mem_we     (mem_we),
    .Cpu_hold   (cpu_hold),
    .Done       (done),
    .Error      (error)
  );

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         gap_pct = 0;
  logic [7:0] fdat [0:255];
  logic [15:0] wq [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory-side observer: every write pulse is captured once, and the loader must not accept bytes then.
  always @(negedge clk) begin
    if (mem_we) begin
      wq.push_back({mem_address, mem_data});
      check_eq("rdy_during_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit sent = 0;
    int t = 0;
    while (!sent && t < 200) begin
      @(negedge clk);
      if ($urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_ready) sent = 1;
      end
      t++;
    end
    if (!sent) check_eq("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || error) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) check_eq("end_timeout", 32'd0, 32'd1);
  endtask

  // Plays one frame (LEN byte, fdat[0..len-1], optional checksum) and compares against the frame rules.
  task automatic run_frame(input string tag, input int len, input bit bad_sum);
    logic [7:0]  lb;
    logic [7:0]  s;
    logic [15:0] ew [$];
    bit          exp_err;
    int          n;
    lb = len[7:0];
    s = 8'd0;
    exp_err = (len == 0) || (len > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < len; i++) begin
        ew.push_back({i[7:0], fdat[i]});
        s = s + fdat[i];
      end
`ifdef LOADER_CHECKSUM_EN
      if (bad_sum) exp_err = 1;
`endif
    end
    wq.delete();
    pulse_start();
    check_eq({tag, "_hold_in_len"}, {31'd0, cpu_hold}, 32'd1);
    check_eq({tag, "_rdy_in_len"}, {31'd0, rx_ready}, 32'd1);
    check_eq({tag, "_flags_cleared"}, {30'd0, done, error}, 32'd0);
    send_byte(lb);
    if (!((len == 0) || (len > DEPTH))) begin
      for (int i = 0; i < len; i++) send_byte(fdat[i]);
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_sum ? (s ^ 8'h01) : s);
`endif
    end
    rx_valid = 1'b0;
    wait_end();
    @(negedge clk);
    check_eq({tag, "_done"}, {31'd0, done}, {31'd0, !exp_err});
    check_eq({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    check_eq({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, exp_err});
    check_eq({tag, "_we_idle"}, {31'd0, mem_we}, 32'd0);
    check_eq({tag, "_nwrites"}, wq.size(), ew.size());
    n = (wq.size() < ew.size()) ? wq.size() : ew.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_write"}, {16'd0, wq[i]}, {16'd0, ew[i]});
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    #12;
    check_eq("rst_outputs", {8'd0, 5'd0, rx_ready, mem_we, cpu_hold, done, error, 1'b0, mem_address, mem_data},
             32'd0);
    @(negedge clk);
    rst = 1'b0;

    fdat[0] = 8'hA1; fdat[1] = 8'hB2; fdat[2] = 8'hC3;
    run_frame("basic3", 3, 0);

    fdat[0] = 8'h10; fdat[1] = 8'h20;
    run_frame("sum_ok", 2, 0);
    run_frame("sum_bad", 2, 1);

    run_frame("len00", 0, 0);
    run_frame("len41", 65, 0);
    fdat[0] = 8'h5A; fdat[1] = 8'hC6;
    run_frame("recover", 2, 0);

    for (int i = 0; i < DEPTH; i++) fdat[i] = 8'($urandom);
    run_frame("full64", 64, 0);
    check_eq("full64_last_addr", {24'd0, (wq.size() > 0) ? wq[wq.size()-1][15:8] : 8'hFF}, 32'h3F);

    for (int k = 0; k < 10; k++) begin
      int  len;
      bit  bad;
      gap_pct = $urandom_range(0, 60);
      len = ($urandom_range(7) == 0) ? (($urandom_range(1) == 0) ? 0 : $urandom_range(65, 255))
                                     : $urandom_range(1, DEPTH);
      bad = ($urandom_range(3) == 0);
      for (int i = 0; i < DEPTH; i++) fdat[i] = 8'($urandom);
      run_frame("rand", len, bad);
    end
    gap_pct = 0;

    // Reset lands in the middle of a cycle, right after the second data byte is taken.
    for (int i = 0; i < 5; i++) fdat[i] = 8'(8'h40 + i);
    pulse_start();
    send_byte(8'd5);
    send_byte(fdat[0]);
    send_byte(fdat[1]);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_outputs", {8'd0, 5'd0, rx_ready, mem_we, cpu_hold, done, error, 1'b0, mem_address, mem_data},
             32'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_rst", 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
